// File: rtl/axi_mem_tester.sv
// AXI4 initiator that writes an address-derived pattern over a region in INCR bursts,
// reads it back and reports pass/fail, the error count and the first failing address.
module axi_mem_tester #(
    parameter int unsigned ADDR_BITS = 32,
    parameter int unsigned DATA_BITS = 64,
    parameter int unsigned ID_BITS   = 5,
    parameter int unsigned BURST_LEN = 8,
    parameter logic [31:0] SEED      = 32'hA5A5_0000,
    parameter int unsigned ERR_BITS  = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [ADDR_BITS-1:0]   base_addr,
    input  logic [15:0]            num_bursts,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [ERR_BITS-1:0]    err_count,
    output logic [ADDR_BITS-1:0]   first_err_addr,

    output logic                   axi_aw_valid,
    input  logic                   axi_aw_ready,
    output logic [ADDR_BITS-1:0]   axi_aw_addr,
    output logic [7:0]             axi_aw_len,
    output logic [2:0]             axi_aw_size,
    output logic [1:0]             axi_aw_burst,
    output logic                   axi_aw_lock,
    output logic [3:0]             axi_aw_cache,
    output logic [2:0]             axi_aw_prot,
    output logic [3:0]             axi_aw_qos,
    output logic [ID_BITS-1:0]     axi_aw_id,

    output logic                   axi_w_valid,
    input  logic                   axi_w_ready,
    output logic [DATA_BITS-1:0]   axi_w_data,
    output logic [DATA_BITS/8-1:0] axi_w_strb,
    output logic                   axi_w_last,

    output logic                   axi_b_ready,
    input  logic                   axi_b_valid,
    input  logic [1:0]             axi_b_resp,
    input  logic [ID_BITS-1:0]     axi_b_id,

    output logic                   axi_ar_valid,
    input  logic                   axi_ar_ready,
    output logic [ADDR_BITS-1:0]   axi_ar_addr,
    output logic [7:0]             axi_ar_len,
    output logic [2:0]             axi_ar_size,
    output logic [1:0]             axi_ar_burst,
    output logic                   axi_ar_lock,
    output logic [3:0]             axi_ar_cache,
    output logic [2:0]             axi_ar_prot,
    output logic [3:0]             axi_ar_qos,
    output logic [ID_BITS-1:0]     axi_ar_id,

    output logic                   axi_r_ready,
    input  logic                   axi_r_valid,
    input  logic [DATA_BITS-1:0]   axi_r_data,
    input  logic [1:0]             axi_r_resp,
    input  logic                   axi_r_last,
    input  logic [ID_BITS-1:0]     axi_r_id
);

    localparam int unsigned BEAT_BYTES = DATA_BITS / 8;
    localparam int unsigned LANES      = DATA_BITS / 32;
    localparam int unsigned BEAT_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    localparam logic [BEAT_W-1:0]    LAST_BEAT    = BEAT_W'(BURST_LEN - 1);
    localparam logic [ADDR_BITS-1:0] BURST_STRIDE = ADDR_BITS'(BURST_LEN * BEAT_BYTES);
    localparam logic [ADDR_BITS-1:0] BEAT_STRIDE  = ADDR_BITS'(BEAT_BYTES);
    localparam logic [7:0]           AX_LEN       = 8'(BURST_LEN - 1);
    localparam logic [2:0]           AX_SIZE      = 3'($clog2(BEAT_BYTES));

    typedef enum logic [2:0] {StIdle, StAw, StW, StB, StAr, StR, StDone} state_e;

    state_e                state_q, state_d;
    logic [ADDR_BITS-1:0]  base_q, base_d;
    logic [15:0]           nbursts_q, nbursts_d;
    logic [15:0]           idx_q, idx_d;
    logic [BEAT_W-1:0]     beat_q, beat_d;
    logic [ERR_BITS-1:0]   err_q, err_d;
    logic [ADDR_BITS-1:0]  first_q, first_d;

    logic [ADDR_BITS-1:0]  burst_addr;
    logic [ADDR_BITS-1:0]  beat_addr;
    logic [31:0]           lane;
    logic [DATA_BITS-1:0]  pattern;
    logic                  last_beat;
    logic                  last_burst;
    logic                  err_hit;
    logic [ADDR_BITS-1:0]  err_addr;

    // IDs are always 0 on issue and ignored on response.
    logic unused_ids;
    assign unused_ids = ^{axi_b_id, axi_r_id};

    assign burst_addr = base_q + ADDR_BITS'(idx_q) * BURST_STRIDE;
    assign beat_addr  = burst_addr + ADDR_BITS'(beat_q) * BEAT_STRIDE;
    assign lane       = 32'(beat_addr) ^ SEED;
    assign pattern    = {LANES{lane}};
    assign last_beat  = (beat_q == LAST_BEAT);
    assign last_burst = (idx_q == nbursts_q - 16'd1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            base_q    <= '0;
            nbursts_q <= '0;
            idx_q     <= '0;
            beat_q    <= '0;
            err_q     <= '0;
            first_q   <= '0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            nbursts_q <= nbursts_d;
            idx_q     <= idx_d;
            beat_q    <= beat_d;
            err_q     <= err_d;
            first_q   <= first_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        nbursts_d = nbursts_q;
        idx_d     = idx_q;
        beat_d    = beat_q;
        err_d     = err_q;
        first_d   = first_q;
        err_hit   = 1'b0;
        err_addr  = burst_addr;

        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    base_d    = base_addr;
                    nbursts_d = num_bursts;
                    idx_d     = '0;
                    beat_d    = '0;
                    err_d     = '0;
                    first_d   = '0;
                    state_d   = (num_bursts == 16'd0) ? StDone : StAw;
                end
            end
            StAw: begin
                if (axi_aw_ready) begin
                    beat_d  = '0;
                    state_d = StW;
                end
            end
            StW: begin
                if (axi_w_ready) begin
                    if (last_beat) state_d = StB;
                    else           beat_d  = beat_q + BEAT_W'(1);
                end
            end
            StB: begin
                if (axi_b_valid) begin
                    err_hit = (axi_b_resp != 2'b00);
                    if (last_burst) begin
                        idx_d   = '0;
                        state_d = StAr;
                    end else begin
                        idx_d   = idx_q + 16'd1;
                        state_d = StAw;
                    end
                end
            end
            StAr: begin
                if (axi_ar_ready) begin
                    beat_d  = '0;
                    state_d = StR;
                end
            end
            StR: begin
                if (axi_r_valid) begin
                    err_hit  = (axi_r_data != pattern) || (axi_r_resp != 2'b00) ||
                               (axi_r_last != last_beat);
                    err_addr = beat_addr;
                    if (last_beat) begin
                        if (last_burst) begin
                            state_d = StDone;
                        end else begin
                            idx_d   = idx_q + 16'd1;
                            state_d = StAr;
                        end
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // err_q is nonzero from the first error on, so it doubles as the first-error flag.
        if (err_hit) begin
            if (err_q != '1) err_d = err_q + ERR_BITS'(1);
            if (err_q == '0) first_d = err_addr;
        end
    end

    always_comb begin
        axi_aw_valid = (state_q == StAw);
        axi_w_valid  = (state_q == StW);
        axi_b_ready  = (state_q == StB);
        axi_ar_valid = (state_q == StAr);
        axi_r_ready  = (state_q == StR);

        // Payloads read as zero whenever their channel is idle, including in reset.
        axi_aw_addr  = axi_aw_valid ? burst_addr : '0;
        axi_aw_len   = axi_aw_valid ? AX_LEN : '0;
        axi_aw_size  = axi_aw_valid ? AX_SIZE : '0;
        axi_aw_burst = axi_aw_valid ? 2'b01 : 2'b00;
        axi_aw_lock  = 1'b0;
        axi_aw_cache = '0;
        axi_aw_prot  = '0;
        axi_aw_qos   = '0;
        axi_aw_id    = '0;

        axi_ar_addr  = axi_ar_valid ? burst_addr : '0;
        axi_ar_len   = axi_ar_valid ? AX_LEN : '0;
        axi_ar_size  = axi_ar_valid ? AX_SIZE : '0;
        axi_ar_burst = axi_ar_valid ? 2'b01 : 2'b00;
        axi_ar_lock  = 1'b0;
        axi_ar_cache = '0;
        axi_ar_prot  = '0;
        axi_ar_qos   = '0;
        axi_ar_id    = '0;

        axi_w_data   = axi_w_valid ? pattern : '0;
        axi_w_strb   = axi_w_valid ? '1 : '0;
        axi_w_last   = axi_w_valid && last_beat;

        busy           = (state_q != StIdle) && (state_q != StDone);
        done           = (state_q == StDone);
        pass           = (state_q == StDone) && (err_q == '0);
        err_count      = err_q;
        first_err_addr = first_q;
    end

endmodule
